// File: rtl/alu_cg_pkg.sv
// Shared types and constants for the ALU clock-gating controller.
//   cg_state_t      : per-domain gating state
//   DEF_IDLE_CYCLES : default idle period before a domain is gated
//   DEF_WAKE_CYCLES : default clock-run period before ready asserts
//   cg_cnt_width()  : width of the shared per-domain idle/wake counter
package alu_cg_pkg;

  typedef enum logic [1:0] {
    GATED  = 2'd0,
    WAKING = 2'd1,
    ACTIVE = 2'd2
  } cg_state_t;

  localparam int unsigned DEF_IDLE_CYCLES = 8;
  localparam int unsigned DEF_WAKE_CYCLES = 2;

  // Counter must hold values up to max(idle, wake)
  function automatic int unsigned cg_cnt_width(input int unsigned idle,
                                               input int unsigned wake);
    int unsigned m;
    m = (idle > wake) ? idle : wake;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alu_cg_icg.sv
// Glitch-free latch-based clock gating cell.
//   clk   : free-running clock
//   reset : asynchronous active-high reset, clears the enable latch
//   en    : registered gating enable
//   gclk  : gated clock = clk AND latched enable
module alu_cg_icg (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic gclk
);

  logic en_lat;

  // Transparent only while clk is low, so en can never truncate a high phase
  always_latch begin
    if (reset) begin
      en_lat <= 1'b0;
    end else if (!clk) begin
      en_lat <= en;
    end
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/alu_clk_gate_ctrl.sv
// Per-domain clock-gating controller for the ALU register banks.
//   clk         : free-running clock
//   reset       : asynchronous active-high reset
//   req         : per-domain operation request, held until ready
//   busy        : per-domain operation-in-flight indication
//   force_on    : global override keeping every domain clocked
//   ready       : domain clocked and able to accept (registered)
//   clk_en      : gating enable per domain (registered)
//   gclk        : gated clock per domain
//   gated       : domain is in GATED state (registered)
//   gate_events : saturating count of ACTIVE->GATED transitions
module alu_clk_gate_ctrl
  import alu_cg_pkg::*;
#(
  parameter int unsigned N_DOM       = 4,
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_DOM-1:0]  req,
  input  logic [N_DOM-1:0]  busy,
  input  logic              force_on,
  output logic [N_DOM-1:0]  ready,
  output logic [N_DOM-1:0]  clk_en,
  output logic [N_DOM-1:0]  gclk,
  output logic [N_DOM-1:0]  gated,
  output logic [CNT_W-1:0]  gate_events
);

  localparam int unsigned CW    = cg_cnt_width(IDLE_CYCLES, WAKE_CYCLES);
  localparam int unsigned SUM_W = $clog2(N_DOM + 1);
  localparam int unsigned ACC_W = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  logic [N_DOM-1:0] gate_now;

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    cg_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          idle_c;
    logic          clk_en_q, ready_q, gated_q;
    logic          clk_en_d, ready_d, gated_d, gate_c;

    assign idle_c = ~req[i] & ~busy[i] & ~force_on;

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= GATED;
        cnt_q    <= '0;
        clk_en_q <= 1'b0;
        ready_q  <= 1'b0;
        gated_q  <= 1'b1;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        clk_en_q <= clk_en_d;
        ready_q  <= ready_d;
        gated_q  <= gated_d;
      end
    end

    // Next state and shared idle/wake counter
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        GATED: begin
          if (req[i] | force_on) begin
            state_d = WAKING;
            cnt_d   = '0;
          end
        end
        WAKING: begin
          if (cnt_q == WAKE_LAST) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ACTIVE: begin
          // Any request, busy or force cycle restarts the idle window
          if (!idle_c) begin
            cnt_d = '0;
          end else if (cnt_q == IDLE_LAST) begin
            state_d = GATED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = GATED;
          cnt_d   = '0;
        end
      endcase
    end

    // Output decode from the upcoming state so outputs register with it
    always_comb begin
      clk_en_d = 1'b0;
      ready_d  = 1'b0;
      gated_d  = 1'b0;
      gate_c   = 1'b0;
      clk_en_d = (state_d != GATED);
      ready_d  = (state_d == ACTIVE);
      gated_d  = (state_d == GATED);
      gate_c   = (state_q == ACTIVE) && (state_d == GATED);
    end

    assign clk_en[i]   = clk_en_q;
    assign ready[i]    = ready_q;
    assign gated[i]    = gated_q;
    assign gate_now[i] = gate_c;

    alu_cg_icg u_icg (
      .clk   (clk),
      .reset (reset),
      .en    (clk_en_q),
      .gclk  (gclk[i])
    );
  end

  logic [SUM_W-1:0] n_gate_c;
  logic [ACC_W-1:0] sum_c;
  logic [CNT_W-1:0] gate_events_d;
  logic [CNT_W-1:0] gate_events_q;

  // Add every domain gating this cycle, saturating at all-ones
  always_comb begin
    n_gate_c = '0;
    for (int unsigned k = 0; k < N_DOM; k++) begin
      n_gate_c = n_gate_c + SUM_W'(gate_now[k]);
    end
    sum_c = ACC_W'(gate_events_q) + ACC_W'(n_gate_c);
    if (sum_c[ACC_W-1:CNT_W] != '0) begin
      gate_events_d = '1;
    end else begin
      gate_events_d = sum_c[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_events_q <= '0;
    end else begin
      gate_events_q <= gate_events_d;
    end
  end

  assign gate_events = gate_events_q;

endmodule

// File: tb/tb_alu_clk_gate_ctrl.sv
// Directed self-checking bench for alu_clk_gate_ctrl (N_DOM=2, IDLE=4,
// WAKE=2, CNT_W=2 so that gate_events saturation is reachable quickly).
`timescale 1ns/1ps
module tb_alu_clk_gate_ctrl;
  import alu_cg_pkg::*;

  localparam int unsigned N_DOM = 2;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             reset;
  logic [N_DOM-1:0] req;
  logic [N_DOM-1:0] busy;
  logic             force_on;
  logic [N_DOM-1:0] ready;
  logic [N_DOM-1:0] clk_en;
  logic [N_DOM-1:0] gclk;
  logic [N_DOM-1:0] gated;
  logic [CNT_W-1:0] gate_events;

  logic icg_rst;
  logic icg_en;
  logic icg_gclk;

  int n_tests;
  int n_fail;

  alu_clk_gate_ctrl #(
    .N_DOM       (N_DOM),
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .busy        (busy),
    .force_on    (force_on),
    .ready       (ready),
    .clk_en      (clk_en),
    .gclk        (gclk),
    .gated       (gated),
    .gate_events (gate_events)
  );

  alu_cg_icg u_icg (
    .clk   (clk),
    .reset (icg_rst),
    .en    (icg_en),
    .gclk  (icg_gclk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // gclk pulse counting and high-phase width tracking
  int    g0_cnt = 0;
  int    g1_cnt = 0;
  int    gi_cnt = 0;
  longint g0_rise, g1_rise, gi_rise;
  longint g_min  = 1000;
  longint gi_min = 1000;

  always @(posedge gclk[0]) begin g0_cnt++; g0_rise = $time; end
  always @(posedge gclk[1]) begin g1_cnt++; g1_rise = $time; end
  always @(posedge icg_gclk) begin gi_cnt++; gi_rise = $time; end
  always @(negedge gclk[0]) if (!reset && ($time - g0_rise) < g_min) g_min = $time - g0_rise;
  always @(negedge gclk[1]) if (!reset && ($time - g1_rise) < g_min) g_min = $time - g1_rise;
  always @(negedge icg_gclk) if (!icg_rst && ($time - gi_rise) < gi_min) gi_min = $time - gi_rise;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req      = '0;
    busy     = '0;
    force_on = 1'b0;
    icg_rst  = 1'b1;
    icg_en   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ticks(4);
    chk("rst_gated",  32'(gated),       32'h3);
    chk("rst_clk_en", 32'(clk_en),      32'h0);
    chk("rst_ready",  32'(ready),       32'h0);
    chk("rst_events", 32'(gate_events), 32'h0);
    chk("rst_gclk0",  32'(g0_cnt),      32'd0);
    chk("rst_gclk1",  32'(g1_cnt),      32'd0);

    // busy alone does not wake
    busy = 2'b11;
    ticks(3);
    chk("busy_nowake", 32'(gated), 32'h3);
    busy = 2'b00;

    // Wake domain 0: clk_en one edge after req, ready WAKE edges later
    req = 2'b01;
    chk("wake_pre_en", 32'(clk_en), 32'h0);
    tick();
    chk("wake_en",     32'(clk_en), 32'h1);
    chk("wake_rdy0",   32'(ready),  32'h0);
    chk("wake_gated",  32'(gated),  32'h2);
    tick();
    chk("wake_rdy1",   32'(ready),  32'h0);
    chk("wake_gclk0",  32'(g0_cnt), 32'd1);
    tick();
    chk("wake_rdy2",   32'(ready),  32'h1);

    // Hold via req, then via busy
    ticks(2);
    req  = 2'b00;
    busy = 2'b01;
    ticks(5);
    chk("busy_hold", 32'(ready), 32'h1);

    // Idle for IDLE cycles -> gate on the 4th
    busy = 2'b00;
    ticks(3);
    chk("idle3_rdy",   32'(ready),       32'h1);
    chk("idle3_en",    32'(clk_en),      32'h1);
    tick();
    chk("gate_en",     32'(clk_en),      32'h0);
    chk("gate_rdy",    32'(ready),       32'h0);
    chk("gate_gated",  32'(gated),       32'h3);
    chk("gate_events", 32'(gate_events), 32'h1);

    // Req on the cycle that would complete the idle window keeps ACTIVE
    req = 2'b01;
    ticks(3);
    chk("rewake_rdy", 32'(ready), 32'h1);
    req = 2'b00;
    ticks(3);
    req = 2'b01;
    tick();
    chk("late_req_rdy", 32'(ready),       32'h1);
    chk("late_req_ev",  32'(gate_events), 32'h1);
    req = 2'b00;
    ticks(3);
    chk("cnt_clr_rdy",  32'(ready),       32'h1);
    tick();
    chk("regate_rdy",   32'(ready),       32'h0);
    chk("regate_ev",    32'(gate_events), 32'h2);
    chk("dom1_no_gclk", 32'(g1_cnt),      32'd0);

    // force_on wakes both and holds them through long idle
    force_on = 1'b1;
    tick();
    chk("force_en",   32'(clk_en), 32'h3);
    chk("force_rdy0", 32'(ready),  32'h0);
    ticks(2);
    chk("force_rdy",  32'(ready),  32'h3);
    ticks(50);
    chk("force_hold", 32'(ready),  32'h3);
    chk("force_gated", 32'(gated), 32'h0);
    force_on = 1'b0;
    ticks(3);
    chk("unforce_rdy", 32'(ready),       32'h3);
    chk("unforce_ev",  32'(gate_events), 32'h2);
    tick();
    chk("dual_gate",   32'(gated),       32'h3);
    chk("dual_sat_ev", 32'(gate_events), 32'h3);

    // Already saturated: stays at max
    force_on = 1'b1;
    ticks(3);
    force_on = 1'b0;
    ticks(4);
    chk("sat_gated", 32'(gated),       32'h3);
    chk("sat_ev",    32'(gate_events), 32'h3);

    // Reset while domain 0 is WAKING with cnt=1
    req = 2'b01;
    ticks(2);
    #1;
    chk("pre_rst_gclk", 32'(gclk), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_en",   32'(clk_en),      32'h0);
    chk("mid_rst_rdy",  32'(ready),       32'h0);
    chk("mid_rst_gclk", 32'(gclk),        32'h0);
    chk("mid_rst_ev",   32'(gate_events), 32'h0);
    req = 2'b00;
    tick();
    reset = 1'b0;
    ticks(3);
    chk("post_rst_gated", 32'(gated),  32'h3);
    chk("post_rst_en",    32'(clk_en), 32'h0);

    // Gating cell with enable toggled at arbitrary phases
    icg_rst = 1'b0;
    for (int j = 0; j < 60; j++) begin
      #($urandom_range(1, 17));
      icg_en = ~icg_en;
    end
    icg_en = 1'b1;
    ticks(3);
    chk("icg_pulses",  32'(gi_cnt > 0), 32'h1);
    chk("icg_min_w",   32'(gi_min),     32'd5);
    chk("gclk_min_w",  32'(g_min),      32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
